console_buffer: RTL and testbench

CONSOLE_BUFFER -- requirements
Module: console_buffer

---
 rtl/console_buffer.sv | 164 ++++++++++++++++
 tb/tb_console_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_buffer.sv
// Console buffer: TX FIFO toward the console sink, RX FIFO fed by a valid/ack capture FSM.
// Optional CONSOLE_BUFFER_ECHO_EN loops every captured RX byte back into the TX FIFO.

module console_buffer_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     rptr_nxt;
  logic [AW:0]       cnt;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] head_nxt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is registered so the read side never sees a combinational path from pop.
  // When the slot that becomes head is being written this edge, forward the write data.
  assign rptr_nxt = do_pop ? rptr + 1'b1 : rptr;
  assign head_nxt = (do_push && (wptr == rptr_nxt)) ? wdata : mem[rptr_nxt];

  // NOTE: storage has no reset; pointers and count define what is valid, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr   <= rptr_nxt;
      head_q <= head_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign head  = head_q;
endmodule

module console_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [DATA_W-1:0]       TX_WDATA,
  input  logic                    TX_WE,
  output logic                    TX_FULL,
  output logic [$clog2(DEPTH):0]  TX_COUNT,
  output logic                    TX_OVF,
  output logic [DATA_W-1:0]       CONSOLE_OUT,
  output logic                    CONSOLE_OUT_valid,
  input  logic                    CONSOLE_OUT_ready,
  input  logic [DATA_W-1:0]       CONSOLE_IN,
  input  logic                    CONSOLE_IN_valid,
  output logic                    CONSOLE_IN_ack,
  output logic [DATA_W-1:0]       RX_RDATA,
  input  logic                    RX_RE,
  output logic                    RX_EMPTY,
  output logic [$clog2(DEPTH):0]  RX_COUNT
);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              rx_full;
  logic              tx_empty;
  logic              capture_ok;
  logic              capture;
  logic              tx_push;
  logic [DATA_W-1:0] tx_wdata;

`ifdef CONSOLE_BUFFER_ECHO_EN
  // Processor writes win; echo only fires into a TX slot nobody else wants, so it cannot overflow.
  assign capture_ok = !rx_full && !TX_FULL && !TX_WE;
  assign tx_push    = TX_WE || capture;
  assign tx_wdata   = capture ? CONSOLE_IN : TX_WDATA;
`else
  assign capture_ok = !rx_full;
  assign tx_push    = TX_WE;
  assign tx_wdata   = TX_WDATA;
`endif

  assign capture = (state == ST_IDLE) && CONSOLE_IN_valid && capture_ok;

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (capture) state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!CONSOLE_IN_valid) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      TX_OVF <= 1'b0;
    end else begin
      state <= state_nxt;
      if (TX_WE && TX_FULL) TX_OVF <= 1'b1;
    end
  end

  assign CONSOLE_IN_ack = (state == ST_ACK);

  console_buffer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (CONSOLE_OUT_ready),
    .full  (TX_FULL),
    .empty (tx_empty),
    .count (TX_COUNT),
    .head  (CONSOLE_OUT)
  );

  assign CONSOLE_OUT_valid = !tx_empty;

  console_buffer_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (capture),
    .wdata (CONSOLE_IN),
    .pop   (RX_RE),
    .full  (rx_full),
    .empty (RX_EMPTY),
    .count (RX_COUNT),
    .head  (RX_RDATA)
  );
endmodule

// File: tb/tb_console_buffer.sv
// Self-checking bench for console_buffer: vector table, directed corner sequences and a
// randomized run against a queue-based model (echo sections follow CONSOLE_BUFFER_ECHO_EN).

module tb_console_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic [DATA_W-1:0] TX_WDATA;
  logic              TX_WE;
  logic              TX_FULL;
  logic [4:0]        TX_COUNT;
  logic              TX_OVF;
  logic [DATA_W-1:0] CONSOLE_OUT;
  logic              CONSOLE_OUT_valid;
  logic              CONSOLE_OUT_ready;
  logic [DATA_W-1:0] CONSOLE_IN;
  logic              CONSOLE_IN_valid;
  logic              CONSOLE_IN_ack;
  logic [DATA_W-1:0] RX_RDATA;
  logic              RX_RE;
  logic              RX_EMPTY;
  logic [4:0]        RX_COUNT;

  int checks = 0;
  int errors = 0;

  console_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .TX_WDATA(TX_WDATA), .TX_WE(TX_WE), .TX_FULL(TX_FULL), .TX_COUNT(TX_COUNT), .TX_OVF(TX_OVF),
    .CONSOLE_OUT(CONSOLE_OUT), .CONSOLE_OUT_valid(CONSOLE_OUT_valid), .CONSOLE_OUT_ready(CONSOLE_OUT_ready),
    .CONSOLE_IN(CONSOLE_IN), .CONSOLE_IN_valid(CONSOLE_IN_valid), .CONSOLE_IN_ack(CONSOLE_IN_ack),
    .RX_RDATA(RX_RDATA), .RX_RE(RX_RE), .RX_EMPTY(RX_EMPTY), .RX_COUNT(RX_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [7:0] wdata;
    logic       rdy;
    int         cnt;
    logic       valid;
    logic [7:0] out;
  } tx_vec_t;

  tx_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N           = 1'b0;
    TX_WE             = 1'b0;
    TX_WDATA          = '0;
    RX_RE             = 1'b0;
    CONSOLE_IN_valid  = 1'b0;
    CONSOLE_IN        = '0;
    CONSOLE_OUT_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (CONSOLE_IN_ack) seen = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tx_full"},  TX_FULL, 0);
    check({tag, " tx_count"}, TX_COUNT, 0);
    check({tag, " out_valid"}, CONSOLE_OUT_valid, 0);
    check({tag, " ack"},      CONSOLE_IN_ack, 0);
    check({tag, " rx_empty"}, RX_EMPTY, 1);
    check({tag, " rx_count"}, RX_COUNT, 0);
    check({tag, " tx_ovf"},   TX_OVF, 0);
  endtask

  // Randomized run against a queue model.
  task automatic random_run(input int cycles);
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] ep_byte;
    bit ovf_m, ep_done, cap, tx_full_m, rx_full_m;
    int hi_left, lo_left, p;
    ovf_m = 0; ep_done = 1; hi_left = 0; lo_left = 2; ep_byte = 8'h00;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      // Valid episodes are separated by at least two low cycles.
      if (hi_left > 0) begin
        CONSOLE_IN_valid = 1'b1; hi_left--;
      end else if (lo_left > 0) begin
        CONSOLE_IN_valid = 1'b0; lo_left--;
      end else begin
        ep_byte = 8'($urandom);
        hi_left = $urandom_range(1, 6) - 1;
        lo_left = $urandom_range(2, 4);
        ep_done = 0;
        CONSOLE_IN_valid = 1'b1;
      end
      CONSOLE_IN = ep_byte;
      p = (cyc / 100) % 2;
      TX_WE             = p ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      TX_WDATA          = 8'($urandom);
      CONSOLE_OUT_ready = p ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      RX_RE             = p ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);

      tx_full_m = (txq.size() == DEPTH);
      rx_full_m = (rxq.size() == DEPTH);
      cap = CONSOLE_IN_valid && !ep_done && !rx_full_m;
`ifdef CONSOLE_BUFFER_ECHO_EN
      cap = cap && !TX_WE && !tx_full_m;
`endif
      if (CONSOLE_OUT_ready && txq.size() > 0) void'(txq.pop_front());
      if (TX_WE) begin
        if (!tx_full_m) txq.push_back(TX_WDATA);
        else ovf_m = 1;
      end
      if (RX_RE && rxq.size() > 0) void'(rxq.pop_front());
      if (cap) begin
        rxq.push_back(ep_byte);
`ifdef CONSOLE_BUFFER_ECHO_EN
        txq.push_back(ep_byte);
`endif
        ep_done = 1;
      end

      tick();
      check("rnd tx_count", TX_COUNT, txq.size());
      check("rnd rx_count", RX_COUNT, rxq.size());
      check("rnd tx_full", TX_FULL, txq.size() == DEPTH);
      check("rnd rx_empty", RX_EMPTY, rxq.size() == 0);
      check("rnd out_valid", CONSOLE_OUT_valid, txq.size() != 0);
      check("rnd tx_ovf", TX_OVF, ovf_m);
      check("rnd ack", CONSOLE_IN_ack, cap);
      if (txq.size() > 0) check("rnd console_out", CONSOLE_OUT, txq[0]);
      if (rxq.size() > 0) check("rnd rx_rdata", RX_RDATA, rxq[0]);
    end
    TX_WE = 0; RX_RE = 0; CONSOLE_IN_valid = 0; CONSOLE_OUT_ready = 0;
  endtask

  initial begin
    bit seen;
    int acks;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h22};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 1, 1'b1, 8'h33};
    vecs[4] = '{1'b1, 8'h44, 1'b1, 1, 1'b1, 8'h44};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 8'h55, 1'b1, 1, 1'b1, 8'h55};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    RESET_N = 1'b1;
    TX_WE = 0; TX_WDATA = '0; RX_RE = 0; CONSOLE_IN_valid = 0; CONSOLE_IN = '0; CONSOLE_OUT_ready = 0;
    #2;

    // Reset values, held and after release.
    RESET_N = 1'b0;
    #1;
    check_idle_outputs("in_reset");
    check("in_reset console_out", CONSOLE_OUT, 0);
    check("in_reset rx_rdata", RX_RDATA, 0);
    do_reset();
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (CONSOLE_IN_ack) acks++;
    end
    check_idle_outputs("idle");
    check("idle ack pulses", acks, 0);

    // Vector table: TX push/pop interplay.
    for (int i = 0; i < 10; i++) begin
      TX_WE = vecs[i].we; TX_WDATA = vecs[i].wdata; CONSOLE_OUT_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d tx_count", i), TX_COUNT, vecs[i].cnt);
      check($sformatf("vec%0d out_valid", i), CONSOLE_OUT_valid, vecs[i].valid);
      if (vecs[i].valid) check($sformatf("vec%0d console_out", i), CONSOLE_OUT, vecs[i].out);
    end
    TX_WE = 0; CONSOLE_OUT_ready = 0;

    // TX fill, overflow, ordered drain.
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      TX_WE = 1; TX_WDATA = 8'(8'h41 + i);
      tick();
    end
    TX_WE = 0;
    check("ovf tx_full", TX_FULL, 1);
    check("ovf tx_count", TX_COUNT, 16);
    check("ovf tx_ovf", TX_OVF, 1);
    CONSOLE_OUT_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("drain valid", CONSOLE_OUT_valid, 1);
      check("drain order", CONSOLE_OUT, 8'(8'h41 + i));
      tick();
    end
    check("drain no 0x51", CONSOLE_OUT_valid, 0);
    check("drain ovf sticky", TX_OVF, 1);
    CONSOLE_OUT_ready = 0;

    // Single capture per valid episode.
    do_reset();
    CONSOLE_IN = 8'h5A; CONSOLE_IN_valid = 1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CONSOLE_IN_ack) acks++;
    end
    check("rx1 acks", acks, 1);
    check("rx1 count", RX_COUNT, 1);
    check("rx1 rdata", RX_RDATA, 8'h5A);
`ifdef CONSOLE_BUFFER_ECHO_EN
    check("rx1 echo count", TX_COUNT, 1);
    check("rx1 echo data", CONSOLE_OUT, 8'h5A);
`else
    check("rx1 no echo", TX_COUNT, 0);
`endif
    CONSOLE_IN_valid = 0;
    tick(); tick();
    CONSOLE_IN = 8'h5B; CONSOLE_IN_valid = 1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (CONSOLE_IN_ack) acks++;
    end
    check("rx2 acks", acks, 1);
    check("rx2 count", RX_COUNT, 2);
    check("rx2 head", RX_RDATA, 8'h5A);
    CONSOLE_IN_valid = 0;

    // RX backpressure while full; no byte lost.
    do_reset();
    CONSOLE_OUT_ready = 1;
    for (int i = 0; i < 16; i++) begin
      CONSOLE_IN = 8'(8'h80 + i); CONSOLE_IN_valid = 1;
      tick();
      CONSOLE_IN_valid = 0;
      tick(); tick();
    end
    check("bp rx_count full", RX_COUNT, 16);
    CONSOLE_IN = 8'h33; CONSOLE_IN_valid = 1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (CONSOLE_IN_ack) acks++;
    end
    check("bp no ack while full", acks, 0);
    RX_RE = 1;
    tick();
    RX_RE = 0;
    wait_ack(2, seen);
    check("bp ack after pop", seen, 1);
    CONSOLE_IN_valid = 0;
    check("bp rx_count refill", RX_COUNT, 16);
    for (int i = 0; i < 16; i++) begin
      check("bp drain order", RX_RDATA, (i < 15) ? 8'(8'h81 + i) : 8'h33);
      RX_RE = 1;
      tick();
    end
    RX_RE = 0;
    check("bp rx_empty", RX_EMPTY, 1);
    RX_RE = 1;
    tick();
    RX_RE = 0;
    check("bp pop empty ignored", RX_COUNT, 0);
    CONSOLE_OUT_ready = 0;

    // Simultaneous push/pop at count 8.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      TX_WE = 1; TX_WDATA = 8'(8'h60 + i);
      tick();
    end
    CONSOLE_OUT_ready = 1;
    for (int i = 0; i < 4; i++) begin
      TX_WDATA = 8'(8'h68 + i);
      tick();
      check("pp tx_count", TX_COUNT, 8);
    end
    TX_WE = 0;
    for (int i = 0; i < 8; i++) begin
      check("pp order", CONSOLE_OUT, 8'(8'h64 + i));
      tick();
    end
    check("pp empty", CONSOLE_OUT_valid, 0);
    CONSOLE_OUT_ready = 0;

    // Reset during ACK, then a still-high valid is captured anew.
    do_reset();
    CONSOLE_IN = 8'h77; CONSOLE_IN_valid = 1;
    wait_ack(3, seen);
    check("rst_ack seen", seen, 1);
    RESET_N = 0;
    #1;
    check("rst_ack ack drop", CONSOLE_IN_ack, 0);
    check("rst_ack rx_count", RX_COUNT, 0);
    check("rst_ack rx_empty", RX_EMPTY, 1);
    @(negedge CLK);
    RESET_N = 1;
    wait_ack(3, seen);
    check("rst_rel recapture", seen, 1);
    check("rst_rel rx_count", RX_COUNT, 1);
    check("rst_rel rx_rdata", RX_RDATA, 8'h77);
    CONSOLE_IN_valid = 0;

`ifdef CONSOLE_BUFFER_ECHO_EN
    // Echo path and processor-write priority.
    do_reset();
    CONSOLE_IN = 8'h0D; CONSOLE_IN_valid = 1;
    tick();
    check("echo ack", CONSOLE_IN_ack, 1);
    check("echo rx_rdata", RX_RDATA, 8'h0D);
    check("echo console_out", CONSOLE_OUT, 8'h0D);
    check("echo out_valid", CONSOLE_OUT_valid, 1);
    CONSOLE_IN_valid = 0;
    do_reset();
    CONSOLE_IN = 8'h0E; CONSOLE_IN_valid = 1; TX_WE = 1; TX_WDATA = 8'h99;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (CONSOLE_IN_ack) acks++;
    end
    check("echo deferred", acks, 0);
    TX_WE = 0;
    wait_ack(2, seen);
    check("echo after we low", seen, 1);
    check("echo rx_rdata2", RX_RDATA, 8'h0E);
    check("echo tx_count", TX_COUNT, 4);
    check("echo no ovf", TX_OVF, 0);
    CONSOLE_IN_valid = 0;
`endif

    do_reset();
    random_run(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
